// File: rtl/score_keeper_if.sv
// -----------------------------------------------------------------------------
// score_keeper_if
//   Bundles the round-result lights, score controls and display outputs of the
//   score keeper. The player side (master) drives the lights and controls; the
//   score keeper (slave) drives the display and status outputs.
//
//   correct_light   player -> keeper  high while a correct result is shown
//   incorrect_light player -> keeper  high while an incorrect result is shown
//   clear           player -> keeper  synchronous score clear
//   show_sel[1:0]   player -> keeper  0 wins, 1 losses, 2 streak, 3 best
//   score_lights    keeper -> player  registered display value
//   round_done      keeper -> player  one-cycle pulse per scored round
//   new_best        keeper -> player  high while the new-best flash is shown
// -----------------------------------------------------------------------------
interface score_keeper_if;
    logic       correct_light;
    logic       incorrect_light;
    logic       clear;
    logic [1:0] show_sel;
    logic [7:0] score_lights;
    logic       round_done;
    logic       new_best;

    modport master (
        output correct_light,
        output incorrect_light,
        output clear,
        output show_sel,
        input  score_lights,
        input  round_done,
        input  new_best
    );

    modport slave (
        input  correct_light,
        input  incorrect_light,
        input  clear,
        input  show_sel,
        output score_lights,
        output round_done,
        output new_best
    );
endinterface

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//   Turns each rising edge of the player's round-result lights into one scored
//   round and keeps saturating win / loss / current-streak / best-streak
//   counters. The selected counter is shown on an 8-bit display; whenever a new
//   best streak is set the display flashes all-ones for FLASH_CYCLES cycles.
//
//   clock   system clock
//   reset   asynchronous, active-high reset
//   bus     score_keeper_if.slave (lights and controls in, display out)
//
//   CNT_W         counter width, 1..8; counters saturate at 2**CNT_W-1
//   FLASH_CYCLES  length of the new-best flash in cycles, >= 1
// -----------------------------------------------------------------------------
module score_keeper #(
    parameter int CNT_W        = 4,
    parameter int FLASH_CYCLES = 20
) (
    input  logic                 clock,
    input  logic                 reset,
    score_keeper_if.slave        bus
);

    localparam int FW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [FW-1:0]    FLASH_LOAD = FW'(FLASH_CYCLES - 1);
    localparam logic [FW-1:0]    FLASH_ONE  = FW'(1);

    typedef enum logic {
        DISPLAY = 1'b0,
        FLASH   = 1'b1
    } state_t;

    state_t           state;
    logic [FW-1:0]    flash_cnt;
    logic [CNT_W-1:0] wins;
    logic [CNT_W-1:0] losses;
    logic [CNT_W-1:0] streak;
    logic [CNT_W-1:0] best;
    logic             prev_c;
    logic             prev_i;

    logic             win_ev;
    logic             loss_ev;
    logic             win_only;
    logic [CNT_W-1:0] streak_inc;
    logic             beat_best;
    logic [7:0]       sel_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        win_ev     = 1'b0;
        loss_ev    = 1'b0;
        win_only   = 1'b0;
        streak_inc = '0;
        beat_best  = 1'b0;
        sel_val    = 8'h00;

        win_ev     = bus.correct_light & ~prev_c;
        loss_ev    = bus.incorrect_light & ~prev_i;
        // Simultaneous rising edges score as a loss only.
        win_only   = win_ev & ~loss_ev;
        streak_inc = sat_inc(streak);
        // A saturated streak equal to best is not "greater", so no re-flash.
        beat_best  = win_only && (streak_inc > best);

        case (bus.show_sel)
            2'd0:    sel_val = 8'(wins);
            2'd1:    sel_val = 8'(losses);
            2'd2:    sel_val = 8'(streak);
            default: sel_val = 8'(best);
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= DISPLAY;
            flash_cnt        <= '0;
            wins             <= '0;
            losses           <= '0;
            streak           <= '0;
            best             <= '0;
            prev_c           <= 1'b0;
            prev_i           <= 1'b0;
            bus.score_lights <= 8'h00;
            bus.round_done   <= 1'b0;
            bus.new_best     <= 1'b0;
        end else begin
            // Edge detectors track the lights even while clearing, so a level
            // held across a clear is not scored afterwards.
            prev_c <= bus.correct_light;
            prev_i <= bus.incorrect_light;

            if (bus.clear) begin
                state            <= DISPLAY;
                flash_cnt        <= '0;
                wins             <= '0;
                losses           <= '0;
                streak           <= '0;
                best             <= '0;
                bus.score_lights <= 8'h00;
                bus.round_done   <= 1'b0;
                bus.new_best     <= 1'b0;
            end else begin
                bus.round_done <= win_ev | loss_ev;

                if (loss_ev) begin
                    losses <= sat_inc(losses);
                    streak <= '0;
                end else if (win_ev) begin
                    wins   <= sat_inc(wins);
                    streak <= streak_inc;
                    if (beat_best) begin
                        best <= streak_inc;
                    end
                end

                if (beat_best) begin
                    // New best: start (or restart) the flash.
                    state            <= FLASH;
                    flash_cnt        <= FLASH_LOAD;
                    bus.score_lights <= 8'hFF;
                    bus.new_best     <= 1'b1;
                end else if (state == FLASH && !loss_ev && flash_cnt != '0) begin
                    state            <= FLASH;
                    flash_cnt        <= flash_cnt - FLASH_ONE;
                    bus.score_lights <= 8'hFF;
                    bus.new_best     <= 1'b1;
                end else begin
                    // Flash expired, aborted by a loss, or plain display.
                    state            <= DISPLAY;
                    flash_cnt        <= '0;
                    bus.score_lights <= sel_val;
                    bus.new_best     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_score_keeper
//   Directed tests for score_keeper with CNT_W=4, FLASH_CYCLES=20. Inputs are
//   driven and outputs sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_score_keeper;

    logic clock;
    logic reset;

    score_keeper_if sk ();

    score_keeper #(
        .CNT_W        (4),
        .FLASH_CYCLES (20)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests;
    int fails;
    int rd_count;
    int nb_count;

    // Advance one clock, then tally the status pulses seen after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (sk.round_done) rd_count++;
        if (sk.new_best)   nb_count++;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        sk.correct_light   = 1'b0;
        sk.incorrect_light = 1'b0;
        sk.clear           = 1'b0;
        sk.show_sel        = 2'd0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        rd_count = 0;
        nb_count = 0;
    endtask

    task automatic pulse_correct();
        sk.correct_light = 1'b1;
        tick();
        sk.correct_light = 1'b0;
        tick();
    endtask

    task automatic pulse_incorrect();
        sk.incorrect_light = 1'b1;
        tick();
        sk.incorrect_light = 1'b0;
        tick();
    endtask

    // Select a counter and return the display one cycle later.
    task automatic read_sel(input logic [1:0] sel, output logic [7:0] val);
        sk.show_sel = sel;
        tick();
        val = sk.score_lights;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset              = 1'b1;
        sk.correct_light   = 1'b0;
        sk.incorrect_light = 1'b0;
        sk.clear           = 1'b0;
        sk.show_sel        = 2'd0;
        #1;
        tests++;
        if (sk.score_lights !== 8'h00 || sk.round_done !== 1'b0 || sk.new_best !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: lights=%h rd=%b nb=%b, need 00 0 0",
                     sk.score_lights, sk.round_done, sk.new_best);
        end
        do_reset();
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            tests++;
            if (v !== 8'h00) begin
                fails++;
                $display("FAIL reset_counter sel=%0d: got %h, need 00", s, v);
            end
        end
    endtask

    task automatic test_hold_win();
        logic [7:0] v;
        int bad_flash;
        do_reset();
        bad_flash = 0;
        sk.correct_light = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sk.new_best && sk.score_lights !== 8'hFF) bad_flash++;
        end
        sk.correct_light = 1'b0;
        tests++;
        if (nb_count !== 20) begin
            fails++;
            $display("FAIL hold_win_flash_len: got %0d cycles, need 20", nb_count);
        end
        tests++;
        if (bad_flash !== 0) begin
            fails++;
            $display("FAIL hold_win_flash_value: %0d flash cycles not FF, need 0", bad_flash);
        end
        tests++;
        if (sk.score_lights !== 8'h01) begin
            fails++;
            $display("FAIL hold_win_wins_display: got %h, need 01", sk.score_lights);
        end
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (rd_count !== 1) begin
            fails++;
            $display("FAIL hold_win_round_done: got %0d pulses, need 1", rd_count);
        end
        read_sel(2'd2, v);
        tests++;
        if (v !== 8'h01) begin
            fails++;
            $display("FAIL hold_win_streak: got %h, need 01", v);
        end
        read_sel(2'd3, v);
        tests++;
        if (v !== 8'h01) begin
            fails++;
            $display("FAIL hold_win_best: got %h, need 01", v);
        end
    endtask

    task automatic test_win_loss();
        logic [7:0] v;
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h03;
        exp_v[1] = 8'h01;
        exp_v[2] = 8'h00;
        exp_v[3] = 8'h03;
        do_reset();
        pulse_correct();
        pulse_correct();
        pulse_correct();
        tests++;
        if (sk.new_best !== 1'b1) begin
            fails++;
            $display("FAIL win_loss_flash_before_loss: new_best=%b, need 1", sk.new_best);
        end
        sk.incorrect_light = 1'b1;
        tick();
        tests++;
        if (sk.new_best !== 1'b0) begin
            fails++;
            $display("FAIL win_loss_abort: new_best=%b after loss, need 0", sk.new_best);
        end
        sk.incorrect_light = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            tests++;
            if (v !== exp_v[s]) begin
                fails++;
                $display("FAIL win_loss_sel=%0d: got %h, need %h", s, v, exp_v[s]);
            end
        end
        tests++;
        if (rd_count !== 4) begin
            fails++;
            $display("FAIL win_loss_round_done: got %0d pulses, need 4", rd_count);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] v;
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h00;
        exp_v[1] = 8'h01;
        exp_v[2] = 8'h00;
        exp_v[3] = 8'h00;
        do_reset();
        sk.correct_light   = 1'b1;
        sk.incorrect_light = 1'b1;
        tick();
        sk.correct_light   = 1'b0;
        sk.incorrect_light = 1'b0;
        tick();
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            tests++;
            if (v !== exp_v[s]) begin
                fails++;
                $display("FAIL simultaneous_sel=%0d: got %h, need %h", s, v, exp_v[s]);
            end
        end
        tests++;
        if (rd_count !== 1 || nb_count !== 0) begin
            fails++;
            $display("FAIL simultaneous_pulses: rd=%0d nb=%0d, need rd=1 nb=0",
                     rd_count, nb_count);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] v;
        logic [7:0] exp_v [4];
        exp_v[0] = 8'h0F;
        exp_v[1] = 8'h00;
        exp_v[2] = 8'h0F;
        exp_v[3] = 8'h0F;
        do_reset();
        for (int i = 0; i < 15; i++) pulse_correct();
        for (int i = 0; i < 30 && sk.new_best; i++) tick();
        tests++;
        if (sk.new_best !== 1'b0) begin
            fails++;
            $display("FAIL saturation_flash_timeout: new_best=%b after 30 cycles, need 0",
                     sk.new_best);
        end
        nb_count = 0;
        for (int i = 0; i < 5; i++) pulse_correct();
        tests++;
        if (nb_count !== 0) begin
            fails++;
            $display("FAIL saturation_no_flash: got %0d flash cycles, need 0", nb_count);
        end
        tests++;
        if (rd_count !== 20) begin
            fails++;
            $display("FAIL saturation_round_done: got %0d pulses, need 20", rd_count);
        end
        for (int s = 3; s >= 0; s--) begin
            read_sel(2'(s), v);
            tests++;
            if (v !== exp_v[s]) begin
                fails++;
                $display("FAIL saturation_sel=%0d: got %h, need %h", s, v, exp_v[s]);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        do_reset();
        pulse_correct();
        pulse_incorrect();
        rd_count = 0;
        nb_count = 0;
        sk.clear         = 1'b1;
        sk.correct_light = 1'b1;
        tick();
        tests++;
        if (sk.round_done !== 1'b0 || sk.new_best !== 1'b0) begin
            fails++;
            $display("FAIL clear_same_cycle: rd=%b nb=%b, need 0 0",
                     sk.round_done, sk.new_best);
        end
        sk.clear = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests++;
        if (rd_count !== 0 || nb_count !== 0) begin
            fails++;
            $display("FAIL clear_held_level: rd=%0d nb=%0d, need 0 0", rd_count, nb_count);
        end
        for (int s = 0; s < 4; s++) begin
            read_sel(2'(s), v);
            tests++;
            if (v !== 8'h00) begin
                fails++;
                $display("FAIL clear_sel=%0d: got %h, need 00", s, v);
            end
        end
        sk.correct_light = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_flash();
        logic [7:0] v;
        do_reset();
        sk.correct_light = 1'b1;
        tick();
        tests++;
        if (sk.new_best !== 1'b1 || sk.round_done !== 1'b1 || sk.score_lights !== 8'hFF) begin
            fails++;
            $display("FAIL mid_flash_setup: nb=%b rd=%b lights=%h, need 1 1 FF",
                     sk.new_best, sk.round_done, sk.score_lights);
        end
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (sk.new_best !== 1'b0 || sk.round_done !== 1'b0 || sk.score_lights !== 8'h00) begin
            fails++;
            $display("FAIL mid_flash_async_reset: nb=%b rd=%b lights=%h, need 0 0 00",
                     sk.new_best, sk.round_done, sk.score_lights);
        end
        sk.correct_light = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        read_sel(2'd3, v);
        tests++;
        if (v !== 8'h00) begin
            fails++;
            $display("FAIL mid_flash_best_after_reset: got %h, need 00", v);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rd_count = 0;
        nb_count = 0;
        test_reset();
        test_hold_win();
        test_win_loss();
        test_simultaneous();
        test_saturation();
        test_clear();
        test_reset_mid_flash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the game player stage.
- Consumes the round-result lights (correct_light / incorrect_light) and converts each rising edge into one scored round.
- Maintains saturating win, loss, current-streak and best-streak counters.
- Drives an 8-bit score display, with a short all-ones flash whenever a new best streak is set.

Parameters:
- CNT_W, 4, width of each score counter (legal 1..8); counters saturate at 2**CNT_W-1.
- FLASH_CYCLES, 20, number of cycles the new-best flash is shown (legal >=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- correct_light  in  1  level from player; high while a correct result is shown.
- incorrect_light  in  1  level from player; high while an incorrect result is shown.
- clear  in  1  synchronous score clear.
- show_sel  in  2  display select: 0 wins, 1 losses, 2 streak, 3 best.
- score_lights  out  8  registered display value.
- round_done  out  1  one-cycle pulse per scored round.
- new_best  out  1  high while the FSM is in FLASH.

Behaviour:
- Reset (async, active-high) clears everything:
  - all counters = 0; prev_c = prev_i = 0; state = DISPLAY;
  - score_lights = 8'h00; round_done = 0; new_best = 0.
- Edge detect:
  - prev_c / prev_i register the inputs every cycle, including during clear.
  - win_ev = correct_light & ~prev_c; loss_ev = incorrect_light & ~prev_i.
  - If both events occur in the same cycle, treat it as a loss only.
- Win event (registered at the same clock edge):
  - wins += 1 (saturating);
  - streak += 1 (saturating);
  - if the new streak > best: best = new streak, and the FSM enters FLASH with flash_cnt = FLASH_CYCLES-1.
  - No best update and no flash once streak is saturated and equal to best.
- Loss event: losses += 1 (saturating); streak = 0; best unchanged.
- round_done: registered; high exactly one cycle, in the cycle after any win_ev or loss_ev sample. A held-high input level produces no further events.
- FSM states and transitions:
  - DISPLAY:
    - score_lights <= zero-extended selected counter, per show_sel.
    - One-cycle latency from a show_sel or counter change.
  - FLASH:
    - score_lights <= 8'hFF; new_best = 1.
    - flash_cnt decrements each cycle; when flash_cnt == 0, next state is DISPLAY.
    - A new best while in FLASH reloads flash_cnt to FLASH_CYCLES-1 and stays in FLASH.
    - A loss event in FLASH aborts to DISPLAY on the next edge.
- Clear:
  - Synchronous; highest priority over events in the same cycle.
  - All counters = 0; state = DISPLAY; round_done = 0 the next cycle; the event in that cycle is discarded.
- Saturation:
  - All counters hold at their maximum and never wrap.
  - streak resets only on a loss or a clear.
- Width rule: counters are CNT_W bits; score_lights upper 8-CNT_W bits are always 0 in DISPLAY.
- Reset mid-FLASH returns immediately (asynchronously) to DISPLAY with all outputs 0.

Test Plan:
- After reset, hold correct_light high for 40 cycles, then low, with show_sel=0 -> exactly one round_done pulse; wins=1; streak=1; best=1; new_best high for 20 cycles with score_lights=8'hFF; then score_lights=8'h01.
- Three win pulses, then one incorrect pulse, show_sel cycled 0..3 -> score_lights reads 3, 1, 0, 3; round_done pulse count = 4; the loss during FLASH drops new_best on the next cycle.
- correct_light and incorrect_light rise in the same cycle -> losses=1, wins=0, streak=0; one round_done pulse; no flash.
- 20 win pulses with CNT_W=4 -> wins=15, streak=15, best=15; the 16th through 20th wins cause no flash; score_lights=8'h0F.
- Asserting clear in the same cycle as a correct_light rising edge -> all counters 0, no round_done, state DISPLAY; holding correct_light high afterwards produces no event.
- Asserting reset asynchronously mid-FLASH (between clock edges) -> new_best, score_lights and round_done go to 0 immediately; after release, show_sel=3 reads 8'h00.
